uart_rx_tx: RTL and testbench
=============================

Name: uart_rx_tx

Overview:
- Full-duplex 8N1 UART: transmitter and receiver sharing one system clock and one baud-rate configuration.
- TX serializes a byte on request; RX deserializes the line and reports completed bytes.
- Sits between fabric logic and the board pin pair.
- TX and RX are functionally independent; loopback, o_TxSerial wired to i_RxSerial, is the primary use case for verification.

Parameters:
SYS_CLOCK, 50000000, system clock frequency in Hz (first positional parameter).
UART_BAUDRATE, 115200, line rate in bit/s (second positional parameter).
Derived localparam CLKS_PER_BIT = SYS_CLOCK / UART_BAUDRATE, integer-truncated (434 at defaults); HALF_BIT = CLKS_PER_BIT / 2 (217).

Ports:
i_SysClock  in  1  system clock; all logic on rising edge.
i_ResetN  in  1  synchronous active-low reset.
i_TxValid  in  1  level transmit request.
i_TxByte  in  8  byte to send; captured on acceptance.
o_TxSerial  out  1  serial line; idle high.
o_TxDone  out  1  one-cycle pulse at end of frame.
i_RxValid  in  1  synchronous receiver clear, active high; tie 0 for normal operation.
i_RxSerial  in  1  asynchronous serial input.
o_RxByte  out  8  last received byte; held until next successful frame.
o_RxDone  out  1  one-cycle pulse when o_RxByte updates.

Behaviour:
- Reset (i_ResetN=0 at a clock edge):
  - o_TxSerial=1; o_TxDone=0; o_RxByte=0; o_RxDone=0.
  - Both FSMs go to IDLE; TX armed.
  - Synchronizer flops reset to 1.
  - Reset mid-frame aborts immediately.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if i_TxValid=1 and armed, latch i_TxByte, clear armed, go to START. o_TxSerial drives 0 from the next cycle (registered output).
  - START and DATA: bit counter 0..7; 12-bit cycle counter 0..CLKS_PER_BIT-1.
  - STOP: o_TxDone=1 in the last cycle of the stop bit, then back to IDLE.
  - Re-arm rule: armed is set only when i_TxValid=0 is sampled. Holding i_TxValid high after o_TxDone produces exactly one frame.
  - Changing i_TxByte mid-frame has no effect.
- RX:
  - i_RxSerial passes through a 2-flop synchronizer; all decisions use the synchronized value.
  - FSM states IDLE, START, DATA, STOP, FINISH.
  - IDLE: on synchronized 0, go to START.
  - START: wait HALF_BIT cycles, then re-sample. If 1, treat as glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift into bit positions 0..7.
  - STOP: sample at mid stop bit. If 1, go to FINISH. If 0 (framing error), discard the byte, keep o_RxByte unchanged, wait for line high, then go to IDLE.
  - FINISH: wait HALF_BIT cycles (end of stop bit), then load o_RxByte, pulse o_RxDone for one cycle, and return to IDLE.
  - With loopback, o_RxDone therefore follows o_TxDone by roughly 2–4 cycles, always within the same frame.
- i_RxValid=1: RX FSM forced to IDLE, o_RxByte=0, o_RxDone=0, no reception while high. Has no effect on TX.
- Simultaneous TX and RX activity is fully independent.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted between data and stop; frame = 11 bit times.
  - RX checks parity at mid-bit. On mismatch it suppresses o_RxDone, leaves o_RxByte unchanged and completes the stop bit normally.
- Undefined: 8N1 exactly as above, with no parity state in either FSM.

Decomposition:
- Package uart_pkg:
  - TX state enum and RX state enum.
  - Function clks_per_bit(sys_clock, baud).
  - Bit-count constant DATA_BITS=8.
  - Counter width localparam (12 bits at defaults; derive with $clog2).
- One sub-module: uart_sync2, the 2-flop synchronizer with synchronous active-low reset and reset value 1.
- TX and RX FSMs stay in the top.

Test Plan:
- Loopback, defaults. Send 0xFF, 0x00, 0x55, 0xAA in sequence, each with i_TxValid held until o_RxDone. Required: o_RxByte equals the sent byte, one o_TxDone and one o_RxDone per byte.
- 0x55 waveform check: o_TxSerial = 0,1,0,1,0,1,0,1,0,1, each level exactly 434 cycles, then idle 1.
- 10 random bytes in loopback: all match; no extra frames while i_TxValid stays high past o_TxDone.
- Assert i_ResetN=0 mid-frame at bit 4, then release: o_TxSerial=1 the next cycle, o_RxDone never pulses, and the next 0xA5 is received correctly.
- Inject a frame with stop bit 0 on i_RxSerial: no o_RxDone, o_RxByte keeps its prior value. Then assert i_RxValid for one cycle: o_RxByte becomes 0x00.
- Inject a 100-cycle low glitch on i_RxSerial: no reception, RX returns to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for uart_rx_tx.
// Parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } txState_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_FINISH,
    RX_BREAK
  } rxState_t;

  function automatic int unsigned clks_per_bit(input int unsigned sys_clock,
                                               input int unsigned baud);
    return sys_clock / baud;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned clksPerBit);
    return $clog2(clksPerBit * DATA_BITS);
  endfunction

  // 12 bits at the default 50 MHz / 115200 configuration.
  localparam int unsigned CNT_W = cnt_width(clks_per_bit(50_000_000, 115_200));

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial input; resets to line-idle (1).
module uart_sync2 (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART (TX and RX FSMs sharing one baud configuration).
// Define UART_PARITY_EN to insert/check an even parity bit (8E1).
module uart_rx_tx
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLOCK     = 50_000_000,
  parameter int unsigned UART_BAUDRATE = 115_200
) (
  input  logic       i_SysClock,
  input  logic       i_ResetN,
  input  logic       i_TxValid,
  input  logic [7:0] i_TxByte,
  output logic       o_TxSerial,
  output logic       o_TxDone,
  input  logic       i_RxValid,
  input  logic       i_RxSerial,
  output logic [7:0] o_RxByte,
  output logic       o_RxDone
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(SYS_CLOCK, UART_BAUDRATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  // Never narrower than the default width; grows for slower line rates.
  localparam int unsigned CW = (cnt_width(CLKS_PER_BIT) > CNT_W) ? cnt_width(CLKS_PER_BIT) : CNT_W;
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_AT      = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] HALF_LAST    = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] BIT_IDX_LAST = BW'(DATA_BITS - 1);

  txState_t               txState;
  logic [CW-1:0]          txCnt;
  logic [BW-1:0]          txBit;
  logic [DATA_BITS-1:0]   txData;
  logic                   txArmed;

  rxState_t               rxState;
  logic [CW-1:0]          rxCnt;
  logic [BW-1:0]          rxBit;
  logic [DATA_BITS-1:0]   rxShift;
  logic                   rxSync;
`ifdef UART_PARITY_EN
  logic                   rxParErr;
`endif

  uart_sync2 rxSyncInst (
    .clk    (i_SysClock),
    .resetN (i_ResetN),
    .d      (i_RxSerial),
    .q      (rxSync)
  );

  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      txState    <= TX_IDLE;
      txCnt      <= '0;
      txBit      <= '0;
      txData     <= '0;
      txArmed    <= 1'b1;
      o_TxSerial <= 1'b1;
      o_TxDone   <= 1'b0;
    end else begin
      o_TxDone <= 1'b0;
      // Re-arming only on a sampled low keeps a held request to one frame.
      if (!i_TxValid) txArmed <= 1'b1;
      case (txState)
        TX_IDLE: begin
          o_TxSerial <= 1'b1;
          txCnt      <= '0;
          txBit      <= '0;
          if (i_TxValid && txArmed) begin
            txData     <= i_TxByte;
            txArmed    <= 1'b0;
            o_TxSerial <= 1'b0;
            txState    <= TX_START;
          end
        end
        TX_START: begin
          if (txCnt == BIT_LAST) begin
            txCnt      <= '0;
            o_TxSerial <= txData[0];
            txState    <= TX_DATA;
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (txCnt == BIT_LAST) begin
            txCnt <= '0;
            if (txBit == BIT_IDX_LAST) begin
`ifdef UART_PARITY_EN
              o_TxSerial <= ^txData;
              txState    <= TX_PARITY;
`else
              o_TxSerial <= 1'b1;
              txState    <= TX_STOP;
`endif
            end else begin
              txBit      <= txBit + 1'b1;
              o_TxSerial <= txData[txBit + 1'b1];
            end
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (txCnt == BIT_LAST) begin
            txCnt      <= '0;
            o_TxSerial <= 1'b1;
            txState    <= TX_STOP;
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          // Registered pulse: set one cycle early so it is high in the last stop cycle.
          if (txCnt == DONE_AT) o_TxDone <= 1'b1;
          if (txCnt == BIT_LAST) begin
            txCnt   <= '0;
            txState <= TX_IDLE;
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      rxState  <= RX_IDLE;
      rxCnt    <= '0;
      rxBit    <= '0;
      rxShift  <= '0;
      o_RxByte <= '0;
      o_RxDone <= 1'b0;
`ifdef UART_PARITY_EN
      rxParErr <= 1'b0;
`endif
    end else begin
      o_RxDone <= 1'b0;
      if (i_RxValid) begin
        rxState  <= RX_IDLE;
        rxCnt    <= '0;
        rxBit    <= '0;
        o_RxByte <= '0;
      end else begin
        case (rxState)
          RX_IDLE: begin
            rxCnt <= '0;
            rxBit <= '0;
            if (!rxSync) rxState <= RX_START;
          end
          RX_START: begin
            if (rxCnt == HALF_LAST) begin
              rxCnt   <= '0;
              rxState <= rxSync ? RX_IDLE : RX_DATA;
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (rxCnt == BIT_LAST) begin
              rxCnt          <= '0;
              rxShift[rxBit] <= rxSync;
              if (rxBit == BIT_IDX_LAST) begin
`ifdef UART_PARITY_EN
                rxState <= RX_PARITY;
`else
                rxState <= RX_STOP;
`endif
              end else begin
                rxBit <= rxBit + 1'b1;
              end
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
`ifdef UART_PARITY_EN
          RX_PARITY: begin
            if (rxCnt == BIT_LAST) begin
              rxCnt    <= '0;
              rxParErr <= rxSync != ^rxShift;
              rxState  <= RX_STOP;
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
`endif
          RX_STOP: begin
            if (rxCnt == BIT_LAST) begin
              rxCnt   <= '0;
              rxState <= rxSync ? RX_FINISH : RX_BREAK;
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
          RX_FINISH: begin
            if (rxCnt == HALF_LAST) begin
              rxCnt   <= '0;
              rxState <= RX_IDLE;
`ifdef UART_PARITY_EN
              if (!rxParErr) begin
`else
              begin
`endif
                o_RxByte <= rxShift;
                o_RxDone <= 1'b1;
              end
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
          RX_BREAK: begin
            // Framing error: byte discarded, resync only once the line is idle again.
            if (rxSync) rxState <= RX_IDLE;
          end
          default: rxState <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Loopback scoreboard bench for uart_rx_tx: expected bytes queued at send time,
// popped by an independent monitor on every o_RxDone; TX waveform checked against the frame bit vector.
module tb_uart_rx_tx;

  localparam int unsigned SYSCLK = 50_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned CPB    = SYSCLK / BAUD;
`ifdef UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       resetN, txValid, rxValid, txSerial, txDone, rxDone, rxSerial;
  logic       loopback, injectLine;
  logic [7:0] txByte, rxByte;

  int          checks = 0;
  int          errors = 0;
  int unsigned txDoneCnt = 0;
  int unsigned rxDoneCnt = 0;
  logic [7:0]  sb[$];

  always #10 clk = ~clk;

  assign rxSerial = loopback ? txSerial : injectLine;

  uart_rx_tx #(.SYS_CLOCK(SYSCLK), .UART_BAUDRATE(BAUD)) dut (
    .i_SysClock (clk),
    .i_ResetN   (resetN),
    .i_TxValid  (txValid),
    .i_TxByte   (txByte),
    .o_TxSerial (txSerial),
    .o_TxDone   (txDone),
    .i_RxValid  (rxValid),
    .i_RxSerial (rxSerial),
    .o_RxByte   (rxByte),
    .o_RxDone   (rxDone)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (txDone === 1'b1) txDoneCnt++;
    if (rxDone === 1'b1) begin
      rxDoneCnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rxSpurious: got byte 0x%0h expected no reception", rxByte);
      end else begin
        check("rxByte", rxByte, sb.pop_front());
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    logic [NBITS-1:0] frame;
    int unsigned      bad = 0;
    int unsigned      idleBad = 0;
    int unsigned      rx0, tx0;
`ifdef UART_PARITY_EN
    frame = {1'b1, ^b, b, 1'b0};
`else
    frame = {1'b1, b, 1'b0};
`endif
    @(negedge clk);
    check("txIdleBefore", txSerial, 1'b1);
    rx0 = rxDoneCnt;
    tx0 = txDoneCnt;
    sb.push_back(b);
    txByte  = b;
    txValid = 1'b1;
    for (int unsigned k = 0; k < NBITS * CPB; k++) begin
      @(negedge clk);
      if (k == 5 * CPB) txByte = ~b;
      if (txSerial !== frame[k / CPB] || txDone !== (k == NBITS * CPB - 1)) bad++;
    end
    check("txWave", bad, 0);
    // Request stays high well past o_TxDone/o_RxDone: the line must stay idle.
    repeat (120) begin
      @(negedge clk);
      if (txSerial !== 1'b1 || txDone !== 1'b0) idleBad++;
    end
    check("txNoRefire", idleBad, 0);
    check("txDoneCount", txDoneCnt - tx0, 1);
    check("rxDoneCount", rxDoneCnt - rx0, 1);
    if (rxDoneCnt == rx0 && sb.size() > 0) void'(sb.pop_back());
    txValid = 1'b0;
    txByte  = 8'($urandom_range(0, 255));
    repeat (2) @(negedge clk);
  endtask

  task automatic injectBits(input logic [15:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      injectLine = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  directed [4];
    logic [15:0] badFrame;
    int unsigned rx0;
    directed = '{8'hFF, 8'h00, 8'h55, 8'hAA};

    resetN = 1'b0; txValid = 1'b0; rxValid = 1'b0; txByte = 8'h00;
    loopback = 1'b1; injectLine = 1'b1;
    repeat (3) @(negedge clk);
    check("rstTxSerial", txSerial, 1'b1);
    check("rstTxDone", txDone, 1'b0);
    check("rstRxByte", rxByte, 8'h00);
    check("rstRxDone", rxDone, 1'b0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    foreach (directed[i]) sendByte(directed[i]);
    repeat (10) sendByte(8'($urandom_range(0, 255)));

    // Reset in the middle of data bit 4 (0x2C has bit 4 low).
    @(negedge clk);
    rx0 = rxDoneCnt;
    txByte = 8'h2C; txValid = 1'b1;
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    check("txMidFrameBit4", txSerial, 1'b0);
    resetN = 1'b0; txValid = 1'b0;
    @(negedge clk);
    check("txAbortIdle", txSerial, 1'b1);
    check("txAbortDone", txDone, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("rxAbortNoDone", rxDoneCnt - rx0, 0);
    check("rxAbortByte", rxByte, 8'h00);
    sendByte(8'hA5);

    // Frame with a low stop bit, then line held low one more bit time.
    loopback = 1'b0; injectLine = 1'b1;
    repeat (4) @(negedge clk);
    rx0 = rxDoneCnt;
`ifdef UART_PARITY_EN
    badFrame = {5'b0, 1'b0, ^8'h5A, 8'h5A, 1'b0};
`else
    badFrame = {6'b0, 1'b0, 8'h5A, 1'b0};
`endif
    injectBits(badFrame, NBITS);
    repeat (CPB) @(negedge clk);
    injectLine = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("rxFrameErrNoDone", rxDoneCnt - rx0, 0);
    check("rxFrameErrHold", rxByte, 8'hA5);
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    check("rxClear", rxByte, 8'h00);

    // 100-cycle low glitch must not start a reception.
    @(negedge clk);
    rx0 = rxDoneCnt;
    injectLine = 1'b0;
    repeat (100) @(negedge clk);
    injectLine = 1'b1;
    repeat (10 * CPB) @(negedge clk);
    check("rxGlitchNoDone", rxDoneCnt - rx0, 0);
    check("rxGlitchByte", rxByte, 8'h00);

    loopback = 1'b1;
    repeat (4) @(negedge clk);
    sendByte(8'($urandom_range(0, 255)));
    check("sbDrain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
